// File: rtl/jtag_dtm_ctrl_if.sv
// DMI request/response channel between the DTM (master) and the Debug Module (slave).
interface jtag_dtm_ctrl_if #(
  parameter int unsigned ADDR_BITS = 6,
  parameter int unsigned DATA_BITS = 32,
  parameter int unsigned OP_BITS   = 2
);
  logic                 req_valid;
  logic                 req_ready;
  logic [ADDR_BITS-1:0] req_addr;
  logic [DATA_BITS-1:0] req_data;
  logic [OP_BITS-1:0]   req_op;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [DATA_BITS-1:0] resp_data;
  logic [OP_BITS-1:0]   resp_op;

  modport master (
    output req_valid, req_addr, req_data, req_op, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_op
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_op, resp_ready,
    output req_ready, resp_valid, resp_data, resp_op
  );
endinterface

// File: rtl/jtag_dtm_ctrl.sv
// JTAG DTM controller: sequences TAP-captured DMI requests onto the DMI channel
// and maintains dtmcs with sticky error status, dmireset and dmihardreset.
module jtag_dtm_ctrl #(
  parameter int unsigned DMI_ADDR_BITS = 6,
  parameter int unsigned DMI_DATA_BITS = 32,
  parameter int unsigned DMI_OP_BITS   = 2,
  parameter int unsigned TAP_REQ_BITS  = DMI_ADDR_BITS + DMI_DATA_BITS + DMI_OP_BITS,
  parameter logic [2:0]  IDLE_HINT     = 3'd1
) (
  input  logic                    jtag_tck_i,
  input  logic                    jtag_trst_ni,
  input  logic                    tap_req_i,
  input  logic [TAP_REQ_BITS-1:0] tap_data_i,
  output logic [TAP_REQ_BITS-1:0] dtm_data_o,
  input  logic                    dtmcs_wr_i,
  input  logic [31:0]             dtmcs_wdata_i,
  output logic [31:0]             dtmcs_o,
  jtag_dtm_ctrl_if.master         dmi
);

  localparam logic [DMI_OP_BITS-1:0] OP_READ   = DMI_OP_BITS'(1);
  localparam logic [DMI_OP_BITS-1:0] OP_WRITE  = DMI_OP_BITS'(2);
  localparam logic [DMI_OP_BITS-1:0] OP_FAILED = DMI_OP_BITS'(2);
  localparam logic [DMI_OP_BITS-1:0] OP_BUSY   = DMI_OP_BITS'(3);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT_RESP} state_e;

  state_e                   state_q, state_d;
  logic [DMI_OP_BITS-1:0]   sticky_q, sticky_d;
  logic [DMI_ADDR_BITS-1:0] req_addr_q, res_addr_q;
  logic [DMI_DATA_BITS-1:0] req_data_q, res_data_q;
  logic [DMI_OP_BITS-1:0]   req_op_q;
  logic [DMI_OP_BITS-1:0]   status_c;

  logic [DMI_ADDR_BITS-1:0] tap_addr;
  logic [DMI_DATA_BITS-1:0] tap_wdata;
  logic [DMI_OP_BITS-1:0]   tap_op;
  logic dtmcs_clear, hard_reset, tap_take, start, busy_hit, resp_fire, resp_err;
  logic unused_wdata;

  assign tap_addr  = tap_data_i[TAP_REQ_BITS-1 -: DMI_ADDR_BITS];
  assign tap_wdata = tap_data_i[DMI_OP_BITS +: DMI_DATA_BITS];
  assign tap_op    = tap_data_i[DMI_OP_BITS-1:0];

  // A dtmcs write owns the cycle: any coincident TAP request is ignored.
  assign dtmcs_clear = dtmcs_wr_i & (dtmcs_wdata_i[16] | dtmcs_wdata_i[17]);
  assign hard_reset  = dtmcs_wr_i & dtmcs_wdata_i[17];
  assign tap_take    = tap_req_i & ~dtmcs_wr_i;
  assign start       = (state_q == ST_IDLE) && tap_take && (sticky_q == '0)
                       && ((tap_op == OP_READ) || (tap_op == OP_WRITE));
  assign busy_hit    = tap_take && (state_q != ST_IDLE);
  assign resp_fire   = (state_q == ST_WAIT_RESP) && dmi.resp_valid && !hard_reset;
  assign resp_err    = resp_fire && ((dmi.resp_op == OP_FAILED) || (dmi.resp_op == OP_BUSY));
  assign unused_wdata = ^{dtmcs_wdata_i[31:18], dtmcs_wdata_i[15:0]};

  // State register
  always_ff @(posedge jtag_tck_i or negedge jtag_trst_ni) begin
    if (!jtag_trst_ni) begin
      state_q  <= ST_IDLE;
      sticky_q <= '0;
    end else begin
      state_q  <= state_d;
      sticky_q <= sticky_d;
    end
  end

  // Next-state and sticky status
  always_comb begin
    state_d  = state_q;
    sticky_d = sticky_q;
    case (state_q)
      ST_IDLE:      if (start)            state_d = ST_REQ;
      ST_REQ:       if (dmi.req_ready)    state_d = ST_WAIT_RESP;
      ST_WAIT_RESP: if (dmi.resp_valid)   state_d = ST_IDLE;
      default:                            state_d = ST_IDLE;
    endcase
    if (hard_reset) state_d = ST_IDLE;

    if (dtmcs_clear)                       sticky_d = '0;
    else if (resp_err)                     sticky_d = dmi.resp_op;
    else if (busy_hit && sticky_q == '0)   sticky_d = OP_BUSY;
  end

  // Outputs decoded from state; IDLE keeps resp_ready high to drain stray responses
  always_comb begin
    dmi.req_valid  = 1'b0;
    dmi.resp_ready = 1'b0;
    status_c       = OP_BUSY;
    case (state_q)
      ST_IDLE: begin
        dmi.resp_ready = 1'b1;
        status_c       = sticky_q;
      end
      ST_REQ:       dmi.req_valid  = 1'b1;
      ST_WAIT_RESP: dmi.resp_ready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge jtag_tck_i or negedge jtag_trst_ni) begin
    if (!jtag_trst_ni) begin
      req_addr_q <= '0;
      req_data_q <= '0;
      req_op_q   <= '0;
      res_addr_q <= '0;
      res_data_q <= '0;
    end else begin
      if (start) begin
        req_addr_q <= tap_addr;
        req_data_q <= tap_wdata;
        req_op_q   <= tap_op;
      end
      if (resp_fire) begin
        res_addr_q <= req_addr_q;
        res_data_q <= dmi.resp_data;
      end
    end
  end

  assign dmi.req_addr = req_addr_q;
  assign dmi.req_data = req_data_q;
  assign dmi.req_op   = req_op_q;

  assign dtm_data_o = {res_addr_q, res_data_q, status_c};
  assign dtmcs_o    = {14'd0, 3'b000, IDLE_HINT, 2'(sticky_q), 6'(DMI_ADDR_BITS), 4'd1};

endmodule
